// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: register
// offsets, CTRL bit positions, MODE encodings and FSM state codes.
// Optional feature macro: TIMER_PRESCALER_EN (adds the CTRL divisor field).
package timer_counter_pkg;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] REG_PRESET = 2'b01;
  localparam logic [1:0] REG_COUNT  = 2'b10;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
`ifdef TIMER_PRESCALER_EN
  localparam int CTRL_DIV_LSB  = 4;
`endif

  // MODE encodings; 1x behaves as one-shot
  localparam logic [1:0] MODE_ONE_SHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } timer_state_e;

  // Only the exact 01 code reloads; every other code is one-shot
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_AUTO_RELOAD);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the timer: produces a one-cycle tick once every
// divisor+1 cycles. The tick is registered, so after a clear the first tick
// appears divisor+1 cycles later. Built only when TIMER_PRESCALER_EN is defined.
`ifdef TIMER_PRESCALER_EN
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] divisor,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_cnt_r;
  logic                  tick_r;

  // Divider counter; restarts from zero on reset or on a timer LOAD
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt_r <= {PRESCALE_W{1'b0}};
      tick_r    <= 1'b0;
    end else if (div_cnt_r == divisor) begin
      div_cnt_r <= {PRESCALE_W{1'b0}};
      tick_r    <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      tick_r    <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule
`endif

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer (one instance per bridge timer slot).
// Registers at addr[3:2]: CTRL (rw), PRESET (rw), COUNT (ro), 11 reads 0.
// Modes: one-shot (interrupt held until a CTRL write) and auto-reload
// (one-cycle interrupt pulse per period).
// Optional feature macro: TIMER_PRESCALER_EN (CTRL divisor slows the count).
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  timer_state_e     state_r, state_nxt_s;
  logic             ctrl_en_r;
  logic [1:0]       ctrl_mode_r;
  logic             ctrl_im_r;
  logic [CNT_W-1:0] preset_r;
  logic [CNT_W-1:0] count_r;
  logic             irq_flag_r;

  logic             ctrl_wr_s, preset_wr_s;
  logic             load_s, dec_s, set_flag_s, clr_flag_s, clr_en_s;
  logic             tick_s;
  logic [31:0]      ctrl_read_s;
  logic             unused_addr_s;

  assign ctrl_wr_s     = we && (addr[3:2] == REG_CTRL);
  assign preset_wr_s   = we && (addr[3:2] == REG_PRESET);
  assign unused_addr_s = ^{addr[31:4], addr[1:0]};

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] ctrl_div_r;

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_s),
    .divisor(ctrl_div_r),
    .tick   (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  // Next-state and datapath control decode for the timer FSM
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    dec_s       = 1'b0;
    set_flag_s  = 1'b0;
    clr_flag_s  = 1'b0;
    clr_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_en_r) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_s      = 1'b1;
        state_nxt_s = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en_r) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s) begin
          if (count_r == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_INT;
            set_flag_s  = 1'b1;
          end else begin
            dec_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_CNT;
        end
      end
      ST_INT: begin
        state_nxt_s = ST_IDLE;
        if (is_auto_reload(ctrl_mode_r)) begin
          clr_flag_s = 1'b1;
        end else begin
          clr_en_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // CTRL register; a bus write takes priority over the one-shot EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_r   <= 1'b0;
      ctrl_mode_r <= MODE_ONE_SHOT;
      ctrl_im_r   <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      ctrl_div_r  <= {PRESCALE_W{1'b0}};
`endif
    end else if (ctrl_wr_s) begin
      ctrl_en_r   <= wdata[CTRL_EN_BIT];
      ctrl_mode_r <= wdata[CTRL_MODE_LSB +: 2];
      ctrl_im_r   <= wdata[CTRL_IM_BIT];
`ifdef TIMER_PRESCALER_EN
      ctrl_div_r  <= wdata[CTRL_DIV_LSB +: PRESCALE_W];
`endif
    end else if (clr_en_s) begin
      ctrl_en_r <= 1'b0;
    end
  end

  // Interrupt flag; any CTRL write acknowledges it, even in the expiry cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      irq_flag_r <= 1'b0;
    end else if (set_flag_s) begin
      irq_flag_r <= 1'b1;
    end else if (clr_flag_s) begin
      irq_flag_r <= 1'b0;
    end
  end

  // PRESET holds the reload value; it only reaches COUNT at the next LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      preset_r <= {CNT_W{1'b0}};
    end else if (preset_wr_s) begin
      preset_r <= wdata[CNT_W-1:0];
    end
  end

  // COUNT loads from PRESET and decrements; zero is terminal, never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      count_r <= preset_r;
    end else if (dec_s) begin
      count_r <= count_r - CNT_ONE;
    end
  end

  // CTRL readback image; unused bits read as zero
  always_comb begin
    ctrl_read_s                         = 32'h0000_0000;
    ctrl_read_s[CTRL_EN_BIT]            = ctrl_en_r;
    ctrl_read_s[CTRL_MODE_LSB +: 2]     = ctrl_mode_r;
    ctrl_read_s[CTRL_IM_BIT]            = ctrl_im_r;
`ifdef TIMER_PRESCALER_EN
    ctrl_read_s[CTRL_DIV_LSB +: PRESCALE_W] = ctrl_div_r;
`endif
  end

  // Combinational read mux following addr
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr[3:2])
      REG_CTRL:   rdata = ctrl_read_s;
      REG_PRESET: rdata = 32'(preset_r);
      REG_COUNT:  rdata = 32'(count_r);
      default:    rdata = 32'h0000_0000;
    endcase
  end

  assign irq = irq_flag_r & ctrl_im_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking directed bench for timer_counter.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rv;
  logic        exp_irq;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    addr  = BASE | {28'h0, off};
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    addr = BASE | {28'h0, off};
    #1;
    d = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    addr  = BASE;
    wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(4'h0, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %0h expected 0", rv); end
    rd(4'h4, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_preset got %0h expected 0", rv); end
    rd(4'h8, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_count got %0h expected 0", rv); end
    rd(4'hC, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_reg3 got %0h expected 0", rv); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b expected 0", irq); end
    wr(4'h8, 32'h0000_0055);
    rd(4'h8, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL count_ro got %0h expected 0", rv); end
    wr(4'h0, 32'hFFFF_F000);
    rd(4'h0, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL ctrl_unused got %0h expected 0", rv); end
    wr(4'h0, 32'h0);
  endtask

  task automatic test_one_shot();
    do_reset();
    wr(4'h4, 32'd5);
    rd(4'h4, rv);
    checks++; if (rv !== 32'd5) begin errors++; $display("FAIL preset_rb got %0h expected 5", rv); end
    wr(4'h0, 32'h9);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      exp_irq = (i == 8);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL oneshot_irq cyc %0d got %0b expected %0b", i, irq, exp_irq); end
    end
    step(3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_hold got %0b expected 1", irq); end
    rd(4'h0, rv);
    checks++; if (rv !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got %0h expected 8", rv); end
    rd(4'h8, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL oneshot_count got %0h expected 0", rv); end
    wr(4'h0, 32'h8);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_ack got %0b expected 0", irq); end
  endtask

  task automatic test_auto_reload();
    do_reset();
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      exp_irq = (i == 6) || (i == 13) || (i == 20);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL reload_irq cyc %0d got %0b expected %0b", i, irq, exp_irq); end
    end
    wr(4'h0, 32'hA);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_stop cyc %0d got %0b expected 0", i, irq); end
    end
  endtask

  task automatic test_mask();
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq cyc %0d got %0b expected 0", i, irq); end
    end
    rd(4'h8, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL mask_count got %0h expected 0", rv); end
    rd(4'h0, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL mask_ctrl got %0h expected 0", rv); end
    wr(4'h0, 32'h8);
    for (int i = 1; i <= 3; i++) begin
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_ack cyc %0d got %0b expected 0", i, irq); end
      step(1);
    end
  endtask

  task automatic test_mid_count();
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    step(6);
    rd(4'h8, rv);
    checks++; if (rv !== 32'd6) begin errors++; $display("FAIL mid_count6 got %0d expected 6", rv); end
    wr(4'h4, 32'd2);
    rd(4'h8, rv);
    checks++; if (rv !== 32'd5) begin errors++; $display("FAIL mid_count5 got %0d expected 5", rv); end
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_irq = (i == 6);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL mid_irq cyc %0d got %0b expected %0b", i, irq, exp_irq); end
    end
    // Re-enable written in the INT cycle: bus write keeps EN set
    wr(4'h0, 32'h9);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_ack got %0b expected 0", irq); end
    step(2);
    rd(4'h8, rv);
    checks++; if (rv !== 32'd2) begin errors++; $display("FAIL mid_reload got %0d expected 2", rv); end
    wr(4'h0, 32'h8);
    rd(4'h8, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL mid_dis got %0d expected 1", rv); end
    step(3);
    rd(4'h8, rv);
    checks++; if (rv !== 32'd1) begin errors++; $display("FAIL mid_frozen got %0d expected 1", rv); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_frozen_irq got %0b expected 0", irq); end
    wr(4'h0, 32'h9);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      if (i == 2) begin
        rd(4'h8, rv);
        checks++; if (rv !== 32'd2) begin errors++; $display("FAIL mid_restart got %0d expected 2", rv); end
      end
      exp_irq = (i == 5);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL mid_reen_irq cyc %0d got %0b expected %0b", i, irq, exp_irq); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd(4'h0, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rstmid_ctrl got %0h expected 0", rv); end
    rd(4'h4, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rstmid_preset got %0h expected 0", rv); end
    rd(4'h8, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rstmid_count got %0h expected 0", rv); end
    step(5);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %0b expected 0", irq); end
  endtask

`ifdef TIMER_PRESCALER_EN
  task automatic test_prescaler();
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h19);
    rd(4'h0, rv);
    checks++; if (rv !== 32'h19) begin errors++; $display("FAIL pre_ctrl got %0h expected 19", rv); end
    for (int i = 1; i <= 9; i++) begin
      step(1);
      if (i == 4) begin
        rd(4'h8, rv);
        checks++; if (rv !== 32'd2) begin errors++; $display("FAIL pre_count4 got %0d expected 2", rv); end
      end
      if (i == 5) begin
        rd(4'h8, rv);
        checks++; if (rv !== 32'd1) begin errors++; $display("FAIL pre_count5 got %0d expected 1", rv); end
      end
      exp_irq = (i == 9);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL pre_irq cyc %0d got %0b expected %0b", i, irq, exp_irq); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mask();
    test_mid_count();
    test_reset_mid();
`ifdef TIMER_PRESCALER_EN
    test_prescaler();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
